// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin share of a single-port 1-cycle-latency RAM between two Avalon-MM masters.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int NUM_WORDS = 2560
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_error,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    logic req0, req1, g0, g1, gnt, oor, acc, rd, wr;
    logic last, rv_q, tag_q, oor_q, err0_q, err1_q;

    // Both requesting: the port that did not win last time goes next.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        g0   = ~(reset | reset_req) & req0 & (~req1 | last);
        g1   = ~(reset | reset_req) & req1 & (~req0 | ~last);
        gnt  = g0 | g1;
        wr   = g1 ? m1_write : m0_write;
        rd   = g1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
        oor  = gnt & (32'(mem_address) >= 32'(NUM_WORDS));
        acc  = gnt & ~oor;
    end

    assign mem_address      = g1 ? m1_address : m0_address;
    assign mem_writedata    = g1 ? m1_writedata : m0_writedata;
    assign mem_byteenable   = acc ? (g1 ? m1_byteenable : m0_byteenable) : '0;
    assign mem_chipselect   = acc;
    assign mem_write        = acc & wr;
    assign mem_clken        = ~reset_req;
    assign m0_waitrequest   = req0 & ~g0;
    assign m1_waitrequest   = req1 & ~g1;
    assign m0_readdatavalid = rv_q & ~tag_q;
    assign m1_readdatavalid = rv_q & tag_q;
    assign m0_readdata      = oor_q ? '0 : mem_readdata;
    assign m1_readdata      = m0_readdata;
    assign m0_error         = err0_q;
    assign m1_error         = err1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last   <= 1'b1;
            rv_q   <= 1'b0;
            tag_q  <= 1'b0;
            oor_q  <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            if (gnt) last <= g1;
            rv_q   <= gnt & rd;
            tag_q  <= g1;
            oor_q  <= oor;
            err0_q <= g0 & oor;
            err1_q <= g1 & oor;
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed stimulus with per-port read-return scoreboards and a behavioural RAM.
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0, reset, reset_req;
    logic [11:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m0_readdatavalid, m0_error;
    logic        m1_waitrequest, m1_readdatavalid, m1_error;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata = '0;

    typedef struct { logic [31:0] d; logic e; } exp_t;
    exp_t q0[$], q1[$];
    exp_t x0, x1;
    int   ntotal = 0, npass = 0, v0 = 0, v1 = 0;
    logic [31:0] ram [0:2559];

    onchip_mem_arbiter dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_error(m0_error),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_error(m1_error),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else mem_readdata <= ram[mem_address];
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        ntotal++;
        if (got === want) npass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Monitor: every readdatavalid pops its port's queue; error must coincide with the expected entry.
    always @(negedge clk) begin
        if (m0_readdatavalid) begin
            v0++;
            if (q0.size() == 0) begin
                ntotal++;
                $display("FAIL m0_unexpected_valid: got valid data %h, want none", m0_readdata);
            end else begin
                x0 = q0.pop_front();
                chk("m0_rdata", m0_readdata, x0.d);
                chk("m0_error", 32'(m0_error), 32'(x0.e));
            end
        end else if (m0_error) begin
            ntotal++;
            $display("FAIL m0_stray_error: got error without valid, want none");
        end
        if (m1_readdatavalid) begin
            v1++;
            if (q1.size() == 0) begin
                ntotal++;
                $display("FAIL m1_unexpected_valid: got valid data %h, want none", m1_readdata);
            end else begin
                x1 = q1.pop_front();
                chk("m1_rdata", m1_readdata, x1.d);
                chk("m1_error", 32'(m1_error), 32'(x1.e));
            end
        end else if (m1_error) begin
            ntotal++;
            $display("FAIL m1_stray_error: got error without valid, want none");
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    endtask

    task automatic push0(input logic [31:0] d, input logic e);
        exp_t x; x.d = d; x.e = e; q0.push_back(x);
    endtask

    task automatic push1(input logic [31:0] d, input logic e);
        exp_t x; x.d = d; x.e = e; q1.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        ram[0] = 32'h1111_0000; ram[1] = 32'h2222_0001;
        ram[12'h020] = 32'hFFFF_FFFF; ram[12'h9FF] = 32'h0009_F9FF;
        idle();
        reset = 1; reset_req = 0;
        m0_read = 1; m1_write = 1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_cs", 32'(mem_chipselect), 0);
        chk("rst_wr", 32'(mem_write), 0);
        chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
        chk("rst_clken", 32'(mem_clken), 1);
        cyc(); reset = 0; idle();
        cyc();

        // Port 0 write then read back
        m0_write = 1; m0_address = 12'h010; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_wr_wait", 32'(m0_waitrequest), 0);
        chk("t1_wr_cs", 32'(mem_chipselect), 1);
        chk("t1_wr_we", 32'(mem_write), 1);
        chk("t1_wr_addr", 32'(mem_address), 32'h010);
        cyc(); m0_write = 0; m0_read = 1; push0(32'hDEADBEEF, 0);
        @(negedge clk);
        chk("t1_rd_wait", 32'(m0_waitrequest), 0);
        chk("t1_rd_we", 32'(mem_write), 0);
        cyc(); idle();
        @(negedge clk);
        chk("t1_m1_idle", 32'({m1_waitrequest, m1_readdatavalid, m1_error}), 0);
        cyc();

        // Sustained dual reads from reset alternate starting with port 0
        reset = 1; cyc(); reset = 0;
        m0_read = 1; m0_address = 12'h000; m1_read = 1; m1_address = 12'h001;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push0(32'h1111_0000, 0); else push1(32'h2222_0001, 0);
            @(negedge clk);
            chk("t2_m0_wait", 32'(m0_waitrequest), 32'(k % 2));
            chk("t2_m1_wait", 32'(m1_waitrequest), 32'(1 - k % 2));
            cyc();
        end
        idle();
        cyc(); cyc();
        chk("t2_v0_count", 32'(v0), 5);
        chk("t2_v1_count", 32'(v1), 4);

        // Port 1 partial write then read back
        m1_write = 1; m1_address = 12'h020; m1_byteenable = 4'h3; m1_writedata = 32'h12345678;
        @(negedge clk);
        chk("t3_be", 32'(mem_byteenable), 32'h3);
        cyc(); m1_write = 0; m1_read = 1; m1_byteenable = 4'hF; push1(32'hFFFF5678, 0);
        cyc(); idle();
        cyc();

        // Last in-range word, then first out-of-range word
        m0_read = 1; m0_address = 12'h9FF; push0(32'h0009_F9FF, 0);
        @(negedge clk);
        chk("t4_last_cs", 32'(mem_chipselect), 1);
        cyc(); m0_address = 12'hA00; push0(32'h0, 1);
        @(negedge clk);
        chk("t4_oor_wait", 32'(m0_waitrequest), 0);
        chk("t4_oor_cs", 32'(mem_chipselect), 0);
        cyc(); idle();
        cyc(); cyc();

        // reset_req after a port 0 grant; port 1 must wait, then win the tie
        m0_read = 1; m0_address = 12'h000; push0(32'h1111_0000, 0);
        cyc(); idle(); reset_req = 1; m1_read = 1; m1_address = 12'h001;
        @(negedge clk);
        chk("t5_m1_stall_a", 32'(m1_waitrequest), 1);
        chk("t5_cs_off", 32'(mem_chipselect), 0);
        chk("t5_clken", 32'(mem_clken), 0);
        cyc();
        @(negedge clk);
        chk("t5_m1_stall_b", 32'(m1_waitrequest), 1);
        cyc(); reset_req = 0; m0_read = 1; m0_address = 12'h000; push1(32'h2222_0001, 0);
        @(negedge clk);
        chk("t5_m1_first", 32'(m1_waitrequest), 0);
        chk("t5_m0_waits", 32'(m0_waitrequest), 1);
        cyc(); m1_read = 0; push0(32'h1111_0000, 0);
        cyc(); idle();
        cyc();

        // Reset during a read request: no grant, no valid, tie goes to port 0 again
        reset = 1; m0_read = 1; m0_address = 12'h000;
        @(negedge clk);
        chk("t6_rst_wait", 32'(m0_waitrequest), 1);
        cyc(); reset = 0; idle();
        @(negedge clk);
        chk("t6_no_rdv", 32'(m0_readdatavalid), 0);
        cyc();
        m0_read = 1; m0_address = 12'h000; m1_read = 1; m1_address = 12'h001;
        push0(32'h1111_0000, 0);
        @(negedge clk);
        chk("t6_tie_m0", 32'(m0_waitrequest), 0);
        chk("t6_tie_m1", 32'(m1_waitrequest), 1);
        cyc(); push1(32'h2222_0001, 0);
        cyc(); idle();
        cyc(); cyc();

        chk("end_q0_empty", 32'(q0.size()), 0);
        chk("end_q1_empty", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
